// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, 3-sample majority vote around
// mid-bit, and a one-entry holding register with a valid/ready handshake.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       int_clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] SAMP_A   = CW'(MID - 1);
  localparam logic [CW-1:0] SAMP_B   = CW'(MID);
  localparam logic [CW-1:0] SAMP_C   = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          samp0_q, samp0_d;
  logic          samp1_q, samp1_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic ds;
  logic maj;

  assign ds  = sync2_q;
  // The third vote is the live synchronized value at count MID+1.
  assign maj = (samp0_q & samp1_q) | (samp0_q & ds) | (samp1_q & ds);

  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      samp0_q     <= 1'b1;
      samp1_q     <= 1'b1;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      samp0_q     <= samp0_d;
      samp1_q     <= samp1_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = din;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    samp0_d     = samp0_q;
    samp1_d     = samp1_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (state_q != IDLE) begin
      if (cnt_q == SAMP_A) samp0_d = ds;
      if (cnt_q == SAMP_B) samp1_d = ds;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!ds) state_d = START;
      end

      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SAMP_C && maj) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
        end
      end

      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SAMP_C) shift_d[bit_idx_q] = maj;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end

      // Leave at the stop decision so a start in the back half is caught.
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SAMP_C) begin
          cnt_d = '0;
          if (maj) begin
            state_d = IDLE;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            state_d     = WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end
      end

      WAIT_IDLE: begin
        cnt_d = '0;
        if (ds) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver, 8 data bits, LSB first. Counterpart of the existing UART transmitter: start bit 0, data[0]..data[7], stop bit 1, idle line high.
- Bit timing is derived directly from int_clk. Default is 9600 baud at 50 MHz.
- A 2-flop synchronizer feeds the serial line in. Each bit is decided by a 3-sample majority vote around mid-bit.
- Received bytes go into a one-entry holding register with a valid/ready handshake toward the position-detection logic.

Parameters:
- CLKS_PER_BIT, 5208: int_clk cycles per bit. Legal minimum is 8. Benches use 16.

Ports:
- int_clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial line, asynchronous to int_clk, idle high
- rx_data  output  8  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available in holding register
- rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready at a posedge
- busy  output  1  high in any state other than IDLE
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: rx_data=0x00, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - Internal: state=IDLE, both synchronizer flops=1, bit counter and clock counter cleared.
  - Reset mid-frame abandons the frame; no partial byte is ever delivered.
- Synchronizer: din passes through 2 flops to give ds. All decisions use ds only.
- Clock counter: counts 0..CLKS_PER_BIT-1 within a bit period. It restarts at 0 on each state entry and at each bit boundary.
- Sample points: M=CLKS_PER_BIT/2 (integer division). Samples are taken at counts M-1, M and M+1. Bit value = majority of the 3 samples, decided at count M+1.
- IDLE:
  - ds=0 → START, counter=0.
- START:
  - Majority=1 → false start: return to IDLE, no outputs.
  - Majority=0 → wait until count CLKS_PER_BIT-1, then DATA with bit index 0.
- DATA:
  - Each majority result is shifted in LSB-first: bit index k goes to rx_data_shift[k].
  - After bit index 7 is decided, wait until end of bit, then STOP.
- STOP, majority decided at M+1:
  - Majority=1, the byte is valid:
    - If rx_valid=0, or rx_valid & rx_ready in the same cycle: load rx_data, rx_valid=1 on the next edge, no overrun.
    - Otherwise: keep the old rx_data/rx_valid, pulse overrun for 1 cycle.
    - In both cases go to IDLE immediately, so the next start can be detected during the back half of the stop bit.
  - Majority=0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE (break or line fault):
  - Stay until ds=1, then IDLE.
  - busy stays high here.
- Handshake:
  - rx_valid & rx_ready at a posedge → rx_valid=0 on that edge, unless a new byte loads on the same edge, in which case rx_valid stays 1 with the new data.
  - rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises exactly 1 cycle after the STOP majority decision, i.e. about 9.5 bit periods plus 4 clocks after the din falling edge.
- Glitch immunity: a low pulse on din shorter than the majority window does not produce a frame. Any single-cycle disagreement within the 3 samples is outvoted.
- Widths: clock counter is clog2(CLKS_PER_BIT) bits; bit index is 3 bits. No counter ever wraps past CLKS_PER_BIT-1.

Test Plan (CLKS_PER_BIT=16):
- Reset, idle line, send 0xA5 8N1, rx_ready=0 → rx_valid=1, rx_data=0xA5 held; frame_err=0, overrun=0; busy low after the stop decision.
- Holding 0xA5 unread, send 0x3C → overrun pulses exactly 1 cycle; rx_data stays 0xA5. Then assert rx_ready → rx_valid=0 next edge.
- Back-to-back 0x00 then 0xFF, stop bits exactly 1 bit, rx_ready held 1 → both bytes delivered in order; no errors; rx_valid re-asserts for 0xFF.
- Send 0x55 with stop bit forced 0, line held low 3 more bit times → frame_err 1-cycle pulse, rx_valid stays 0, busy=1 until line high. A following 0x81 is received correctly.
- din low pulse of 3 cycles from idle → false start, no rx_valid, no frame_err. Single-cycle inverted glitch at sample M of data bit 2 of 0x0F → rx_data=0x0F.
- rst_n asserted at data bit 4 of a frame, released 2 cycles later, then 0x96 sent → all outputs 0 during reset, no partial byte, 0x96 received.
